// File: rtl/vga_pkg.sv
// Shared constants and types for the glyph serializer and its scan counter.
package vga_pkg;

  localparam int GLYPH_W = 7;
  localparam int GLYPH_H = 8;

  localparam logic [5:0] CH_SLASH       = 6'h24;
  localparam logic [5:0] CH_SPACE       = 6'h3E;
  localparam logic [5:0] CH_COLON       = 6'h3F;
  localparam logic [5:0] CH_DEFAULT_MIN = 6'h25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2,
    EMIT = 2'd3
  } glyph_ser_state_t;

endpackage

// File: rtl/glyph_scan_counter.sv
// Nested raster counters for one glyph: row > vrep > col > hrep (outermost first).
// Every counter wraps by comparing against its terminal value, so the widths
// never rely on natural overflow.
module glyph_scan_counter
  import vga_pkg::*;
#(
  parameter int SCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       advance_i,
  output logic [2:0] row_o,
  output logic [2:0] col_o,
  output logic       eol_o,
  output logic       eog_o
);

  localparam int              RW       = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam logic [RW-1:0]   REP_LAST = RW'(SCALE - 1);
  localparam logic [RW-1:0]   REP_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0]   REP_ONE  = RW'(1);
  localparam logic [2:0]      COL_LAST = 3'(GLYPH_W - 1);
  localparam logic [2:0]      ROW_LAST = 3'(GLYPH_H - 1);

  logic [2:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic [RW-1:0] vrep_q, vrep_d;
  logic [RW-1:0] hrep_q, hrep_d;

  // Next-state of the nested counters: clear on capture, step on a completed beat.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    vrep_d = vrep_q;
    hrep_d = hrep_q;
    if (clear_i) begin
      row_d  = 3'd0;
      col_d  = 3'd0;
      vrep_d = REP_ZERO;
      hrep_d = REP_ZERO;
    end else if (advance_i) begin
      if (hrep_q != REP_LAST) begin
        hrep_d = hrep_q + REP_ONE;
      end else begin
        hrep_d = REP_ZERO;
        if (col_q != COL_LAST) begin
          col_d = col_q + 3'd1;
        end else begin
          col_d = 3'd0;
          if (vrep_q != REP_LAST) begin
            vrep_d = vrep_q + REP_ONE;
          end else begin
            vrep_d = REP_ZERO;
            if (row_q != ROW_LAST) begin
              row_d = row_q + 3'd1;
            end else begin
              row_d = 3'd0;
            end
          end
        end
      end
    end else begin
      hrep_d = hrep_q;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row_q  <= 3'd0;
      col_q  <= 3'd0;
      vrep_q <= REP_ZERO;
      hrep_q <= REP_ZERO;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      vrep_q <= vrep_d;
      hrep_q <= hrep_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;
  assign eol_o = (col_q == COL_LAST) && (hrep_q == REP_LAST);
  assign eog_o = eol_o && (row_q == ROW_LAST) && (vrep_q == REP_LAST);

endmodule

// File: rtl/glyph_serializer.sv
// Glyph ROM consumer: accepts a character code, fetches its seven column
// words from the external ROM and streams the glyph row-major as pixel beats,
// each pixel replicated SCALE times in both directions.
module glyph_serializer
  import vga_pkg::*;
#(
  parameter int SCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] in_code,
  output logic [5:0] glyph_code,
  input  logic [7:0] glyph_col0,
  input  logic [7:0] glyph_col1,
  input  logic [7:0] glyph_col2,
  input  logic [7:0] glyph_col3,
  input  logic [7:0] glyph_col4,
  input  logic [7:0] glyph_col5,
  input  logic [7:0] glyph_col6,
  output logic       px_valid,
  input  logic       px_ready,
  output logic       px_bit,
  output logic       px_eol,
  output logic       px_eog
);

  glyph_ser_state_t                   state_q, state_d;
  logic [5:0]                         code_q, code_d;
  logic [GLYPH_W-1:0][GLYPH_H-1:0]    glyph_q, glyph_d;

  logic       emit_s;
  logic       clear_s;
  logic       advance_s;
  logic [2:0] row_s;
  logic [2:0] col_s;
  logic       eol_s;
  logic       eog_s;

  assign emit_s    = (state_q == EMIT);
  assign clear_s   = (state_q == CAPT);
  assign advance_s = emit_s && px_ready;

  glyph_scan_counter #(
    .SCALE(SCALE)
  ) u_scan (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear_s),
    .advance_i (advance_s),
    .row_o     (row_s),
    .col_o     (col_s),
    .eol_o     (eol_s),
    .eog_o     (eog_s)
  );

  // FSM next state, code capture and glyph capture.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    glyph_d = glyph_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          code_d  = in_code;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        state_d = CAPT;
      end
      CAPT: begin
        glyph_d = {glyph_col6, glyph_col5, glyph_col4, glyph_col3,
                   glyph_col2, glyph_col1, glyph_col0};
        state_d = EMIT;
      end
      EMIT: begin
        if (px_ready && eog_s) begin
          state_d = IDLE;
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, code and glyph registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      code_q  <= 6'd0;
      glyph_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      glyph_q <= glyph_d;
    end
  end

  // Outputs depend only on state and registers; the ROM sees code_q at all
  // times so its registered column words stay stable through the glyph.
  assign in_ready   = (state_q == IDLE);
  assign glyph_code = code_q;
  assign px_valid   = emit_s;
  assign px_bit     = emit_s && glyph_q[col_s][row_s];
  assign px_eol     = emit_s && eol_s;
  assign px_eog     = emit_s && eog_s;

endmodule

// File: tb/tb_glyph_serializer.sv
// Scoreboard bench for glyph_serializer: a behavioural glyph ROM feeds two
// instances (SCALE=1 and SCALE=2); expected beats are queued when a code is
// offered and popped by per-instance monitors on every completed beat.
module tb_glyph_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid1, in_ready1, px_valid1, px_ready1, px_bit1, px_eol1, px_eog1;
  logic [5:0] in_code1, glyph_code1;
  logic [7:0] rom1 [7];
  logic       in_valid2, in_ready2, px_valid2, px_ready2, px_bit2, px_eol2, px_eog2;
  logic [5:0] in_code2, glyph_code2;
  logic [7:0] rom2 [7];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  bit rand_en   = 1'b0;

  glyph_serializer #(.SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_code(in_code1),
    .glyph_code(glyph_code1),
    .glyph_col0(rom1[0]), .glyph_col1(rom1[1]), .glyph_col2(rom1[2]), .glyph_col3(rom1[3]),
    .glyph_col4(rom1[4]), .glyph_col5(rom1[5]), .glyph_col6(rom1[6]),
    .px_valid(px_valid1), .px_ready(px_ready1), .px_bit(px_bit1), .px_eol(px_eol1), .px_eog(px_eog1)
  );

  glyph_serializer #(.SCALE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_code(in_code2),
    .glyph_code(glyph_code2),
    .glyph_col0(rom2[0]), .glyph_col1(rom2[1]), .glyph_col2(rom2[2]), .glyph_col3(rom2[3]),
    .glyph_col4(rom2[4]), .glyph_col5(rom2[5]), .glyph_col6(rom2[6]),
    .px_valid(px_valid2), .px_ready(px_ready2), .px_bit(px_bit2), .px_eol(px_eol2), .px_eog(px_eog2)
  );

  // Glyph bitmaps written as displayed rows, leftmost pixel first; row 0 in the MSBs.
  function automatic logic [6:0] glyph_row(input logic [5:0] code, input int r);
    logic [55:0] t;
    case (code)
      6'h1D: t = {7'b0111110, {6{7'b0001000}}, 7'b0000000};
      6'h24: t = {7'b0000001, 7'b0000001, 7'b0000010, 7'b0000100,
                  7'b0001000, 7'b0010000, 7'b0100000, 7'b1000000};
      6'h01: t = {7'b0001000, 7'b0011000, {4{7'b0001000}}, 7'b0111110, 7'b0000000};
      6'h08: t = {7'b0111110, 7'b1000001, 7'b1000001, 7'b0111110,
                  7'b1000001, 7'b1000001, 7'b0111110, 7'b0000000};
      6'h3F: t = {7'b0000000, 7'b0001000, 7'b0000000, 7'b0000000,
                  7'b0000000, 7'b0001000, 7'b0000000, 7'b0000000};
      default: t = {7'b0000000, 7'b0100010, 7'b0010100, 7'b1111111,
                    7'b0010100, 7'b0100010, 7'b0000000, 7'b0000000};
    endcase
    return t[55-7*r -: 7];
  endfunction

  // ROM column word: bit r is row r of column c.
  function automatic logic [7:0] col_word(input logic [5:0] code, input int c);
    logic [7:0] w;
    logic [6:0] rw;
    for (int r = 0; r < 8; r++) begin
      rw   = glyph_row(code, r);
      w[r] = rw[6-c];
    end
    return w;
  endfunction

  // Registered behavioural ROMs, one per instance.
  always @(posedge clk) begin
    for (int c = 0; c < 7; c++) begin
      rom1[c] <= col_word(glyph_code1, c);
      rom2[c] <= col_word(glyph_code2, c);
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [2:0] q1 [$];
  logic [2:0] q2 [$];

  // Expected {bit, eol, eog} sequence for a glyph at scale s.
  task automatic push_exp(input int which, input logic [5:0] code, input int s);
    logic [6:0] rw;
    logic       e_eol, e_eog;
    for (int r = 0; r < 8; r++)
      for (int vr = 0; vr < s; vr++)
        for (int c = 0; c < 7; c++)
          for (int hr = 0; hr < s; hr++) begin
            rw    = glyph_row(code, r);
            e_eol = (c == 6) && (hr == s - 1);
            e_eog = e_eol && (r == 7) && (vr == s - 1);
            if (which == 1) q1.push_back({rw[6-c], e_eol, e_eog});
            else            q2.push_back({rw[6-c], e_eol, e_eog});
          end
  endtask

  int beats1 = 0, eols1 = 0, eog_cyc1 = -10;
  int beats2 = 0, eols2 = 0;
  bit stall1 = 1'b0;
  logic [2:0] held1, exp1, exp2;

  // Monitor for the SCALE=1 instance: beat scoreboard plus stall stability.
  always @(negedge clk) begin
    if (rst) begin
      if (stall1) check("stall_hold1", {px_valid1, px_bit1, px_eol1, px_eog1}, {1'b1, held1});
      if (px_valid1 && px_ready1) begin
        if (q1.size() == 0) check("unexpected_beat1", 32'd1, 32'd0);
        else begin
          exp1 = q1.pop_front();
          check($sformatf("beat1_%0d", beats1), {px_bit1, px_eol1, px_eog1}, exp1);
        end
        beats1++;
        if (px_eol1) eols1++;
        if (px_eog1) eog_cyc1 = cyc;
        stall1 = 1'b0;
      end else if (px_valid1) begin
        stall1 = 1'b1;
        held1  = {px_bit1, px_eol1, px_eog1};
      end else stall1 = 1'b0;
    end else stall1 = 1'b0;
  end

  // Monitor for the SCALE=2 instance.
  always @(negedge clk) begin
    if (rst && px_valid2 && px_ready2) begin
      if (q2.size() == 0) check("unexpected_beat2", 32'd1, 32'd0);
      else begin
        exp2 = q2.pop_front();
        check($sformatf("beat2_%0d", beats2), {px_bit2, px_eol2, px_eog2}, exp2);
      end
      beats2++;
      if (px_eol2) eols2++;
    end
  end

  // Random backpressure on the SCALE=1 instance when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) px_ready1 = 1'($urandom_range(0, 1));
    end
  end

  task automatic send1(input logic [5:0] code, input bit chk_lat);
    int n;
    @(posedge clk); #1;
    in_code1 = code; in_valid1 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready1 && n < 5000);
    if (!in_ready1) check("accept_timeout1", 32'd0, 32'd1);
    push_exp(1, code, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    if (chk_lat) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!px_valid1 && n < 10);
      check($sformatf("latency_%0h", code), n, 3);
    end
  endtask

  task automatic wait_done1(input string name);
    int n = 0;
    while (q1.size() != 0 && n < 8000) begin @(negedge clk); n++; end
    check({name, "_drained"}, q1.size(), 0);
  endtask

  task automatic wait_done2(input string name);
    int n = 0;
    while (q2.size() != 0 && n < 8000) begin @(negedge clk); n++; end
    check({name, "_drained"}, q2.size(), 0);
  endtask

  initial begin
    int b0, e0, n;
    rst = 1'b0;
    in_valid1 = 1'b0; in_code1 = 6'd0; px_ready1 = 1'b1;
    in_valid2 = 1'b0; in_code2 = 6'd0; px_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready1", in_ready1, 1);
    check("rst_glyph_code1", glyph_code1, 0);
    check("rst_px1", {px_valid1, px_bit1, px_eol1, px_eog1}, 0);
    check("rst_in_ready2", in_ready2, 1);
    check("rst_px2", {px_valid2, px_bit2, px_eol2, px_eog2}, 0);
    @(posedge clk); #1 rst = 1'b1;

    // 'T' at scale 1 with latency, beat and eol counts.
    b0 = beats1; e0 = eols1;
    send1(6'h1D, 1'b1);
    wait_done1("T");
    check("T_beats", beats1 - b0, 56);
    check("T_eols", eols1 - e0, 8);

    // '/' confirms orientation.
    send1(6'h24, 1'b1);
    wait_done1("slash");

    // '1' at scale 2.
    @(posedge clk); #1;
    in_code2 = 6'h01; in_valid2 = 1'b1;
    push_exp(2, 6'h01, 2);
    @(posedge clk); #1 in_valid2 = 1'b0;
    wait_done2("one_x2");
    check("one_x2_beats", beats2, 224);
    check("one_x2_eols", eols2, 16);

    // '8' under random backpressure, in_valid held high with a follow-on '/'.
    rand_en = 1'b1;
    @(posedge clk); #1;
    in_code1 = 6'h08; in_valid1 = 1'b1;
    @(negedge clk);
    check("hold_first_ready", in_ready1, 1);
    push_exp(1, 6'h08, 1);
    @(posedge clk); #1 in_code1 = 6'h24;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready1 && n < 5000);
    check("hold_ready_after_eog", cyc, eog_cyc1 + 1);
    check("hold_queue_empty", q1.size(), 0);
    push_exp(1, 6'h24, 1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    wait_done1("hold_slash");
    rand_en = 1'b0;
    @(posedge clk); #1 px_ready1 = 1'b1;

    // Reset in the middle of a glyph, after 20 beats.
    b0 = beats1;
    send1(6'h08, 1'b0);
    n = 0;
    while ((beats1 - b0) < 20 && n < 2000) begin @(posedge clk); n++; end
    check("abort_reached_20", beats1 - b0, 20);
    #1 rst = 1'b0; px_ready1 = 1'b0;
    @(posedge clk); #1 rst = 1'b1; px_ready1 = 1'b1;
    @(negedge clk);
    check("abort_px_valid", px_valid1, 0);
    check("abort_in_ready", in_ready1, 1);
    check("abort_glyph_code", glyph_code1, 0);
    q1.delete();
    b0 = beats1;
    repeat (3) @(negedge clk);
    check("abort_no_beats", beats1 - b0, 0);

    // ':' streams cleanly after the abort, then an undefined code.
    send1(6'h3F, 1'b1);
    wait_done1("colon");
    send1(6'h30, 1'b1);
    wait_done1("undef");
    @(negedge clk);
    check("undef_idle", in_ready1, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/glyph_serializer.md
# glyph_serializer

Consumer side of the glyph ROM interface. It accepts one 6-bit character code per transaction and drives that code to the glyph ROM. It captures the ROM's seven registered 8-bit column words, then streams the glyph as a row-major pixel sequence with a per-pixel valid/ready handshake, optionally magnified by an integer scale. It sits between the text buffer / cursor logic and the VGA pixel mux.

## Interface
- SCALE, default 1, pixel replication factor applied both horizontally and vertically (1..4).
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- in_valid  in  1  character code offered.
- in_ready  out  1  block can accept a code.
- in_code  in  6  character code (same encoding as the glyph ROM: 0x00-0x09 digits, 0x0A-0x23 A-Z, 0x24 '/', 0x3E space, 0x3F ':').
- glyph_code  out  6  code driven to the glyph ROM.
- glyph_col0 … glyph_col6  in  8 each  ROM column words; bit k is row k (bit 0 = top); registered in the ROM, valid one clock after glyph_code.
- px_valid  out  1  pixel beat valid.
- px_ready  in  1  downstream accepts the beat.
- px_bit  out  1  1 = foreground.
- px_eol  out  1  beat is the last pixel of a displayed row.
- px_eog  out  1  beat is the last pixel of the glyph.

## Operation
- FSM states: IDLE, REQ, CAPT, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: code_q<=in_code, go to REQ.
- REQ: one cycle. glyph_code=code_q; the ROM samples it at the end of this cycle.
- CAPT:
  - One cycle.
  - Latch glyph_col0..6 into a 7x8 glyph register.
  - Clear all counters.
  - Go to EMIT.
- EMIT:
  - px_valid=1 and px_bit=glyph[col][row].
  - A beat completes on px_valid & px_ready.
  - Nested counters, outermost first: row 0..7, vrep 0..SCALE-1, col 0..6, hrep 0..SCALE-1.
  - The counters advance only on a completed beat.
- px_eol=1 when col==6 and hrep==SCALE-1.
- px_eog=1 when px_eol and row==7 and vrep==SCALE-1.
- A completed beat with px_eog returns the FSM to IDLE.
- Beats per glyph: 56·SCALE²; eol beats per glyph: 8·SCALE.
- in_ready=0 in REQ, CAPT and EMIT. Codes are never accepted mid-glyph.
- Unknown codes are not filtered; the ROM's default glyph ('*') is streamed as returned.
- glyph_code holds code_q in every state, so the ROM output stays stable.

## Timing
- Reset (rst=0 at a rising edge) applies regardless of state:
  - FSM to IDLE; code_q, glyph register and all counters to 0.
  - Outputs: in_ready=1, glyph_code=0, px_valid=0, px_bit=0, px_eol=0, px_eog=0.
- Reset during EMIT aborts the glyph. No further beats follow, and no eog is produced for the aborted glyph.
- Latency: code accepted at edge N; REQ during cycle N+1; CAPT during N+2; first px_valid in cycle N+3.
- Backpressure:
  - While px_valid & !px_ready, px_bit/px_eol/px_eog and all counters hold.
  - px_valid never drops before the beat completes.
- The last beat completes at edge M. The block is in IDLE in cycle M+1 with in_ready=1.
- Minimum per-glyph period: 56·SCALE² + 3 cycles.
- Counter widths:
  - col: 3 bits; row: 3 bits.
  - hrep and vrep: clog2(SCALE) bits, minimum 1.
  - Wrap is compare-to-terminal, never natural overflow.
- Outputs are combinational from state and registers only. There is no input-to-output combinational path except px_ready gating the counters.

## Structure
- vga_pkg holds:
  - GLYPH_W=7, GLYPH_H=8.
  - Code constants CH_SLASH=6'h24, CH_SPACE=6'h3E, CH_COLON=6'h3F, CH_DEFAULT_MIN=6'h25.
  - The glyph_ser_state_t enum (IDLE/REQ/CAPT/EMIT).
- One sub-module is natural: glyph_scan_counter. It contains the four nested counters and generates eol/eog, and is parameterised by SCALE.
- The glyph ROM is instantiated beside this block at top level, not inside it.

## Test plan
- SCALE=1, code 0x1D ('T'), px_ready=1:
  - First px_valid exactly 3 cycles after accept.
  - Row 0 = 0111110; row 1 = 0001000; rows 2-6 = 0001000; row 7 = 0000000.
  - 56 beats; eol on beats 7,14,…,56; eog only on beat 56.
- SCALE=1, code 0x24 ('/'):
  - Row 0 = 0000001; row 1 = 0000001; row 7 = 1000000.
  - Confirms bit 0 = top and col0 = leftmost.
- SCALE=2, code 0x01 ('1'):
  - 224 beats.
  - Row 0 displayed as 00000011000000 twice, then eol twice per glyph row.
  - eog on beat 224.
- Random px_ready (≈50%) on code 0x08 ('8'):
  - The captured pixel stream is identical to the px_ready=1 run.
  - Outputs are stable across every stalled cycle.
  - in_valid held high throughout is not accepted until the cycle after eog.
- Deassert rst during EMIT (beat 20):
  - Next cycle: px_valid=0, in_ready=1, glyph_code=0.
  - A new code 0x3F (':') then streams correctly from row 0.
- Code 0x30 (undefined): the stream equals the '*' glyph from the ROM (row 1 = 0100010), with no hang.
